// File: rtl/ir_prefetch_queue_pkg.sv
// Shared constants and helpers for the SAP instruction prefetch queue.
package ir_prefetch_queue_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefOpcW   = 4;
  localparam int unsigned DefDepth  = 4;
  localparam int unsigned NopOpcode = 0;

  // Queue operation requested this cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OpNone = 2'b00,
    OpPop  = 2'b01,
    OpPush = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  function automatic int unsigned count_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ir_prefetch_queue_if.sv
// Controller-side signal bundle of the prefetch queue; the operand bus itself stays a port.
interface ir_prefetch_queue_if
  import ir_prefetch_queue_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned OpcW  = DefOpcW,
  parameter int unsigned Depth = DefDepth
) ();

  localparam int unsigned CntW = count_w(Depth);

  logic [Width-1:0] ir_in;
  logic             en_ir_in_n;
  logic             ir_next_n;
  logic             ir_flush_n;
  logic             en_ir_out_n;
  logic [OpcW-1:0]  opcode;
  logic             ir_out_oe;
  logic             cur_valid;
  logic [CntW-1:0]  count;
  logic             empty;
  logic             full;
  logic             overflow;

  modport master (
    output ir_in, en_ir_in_n, ir_next_n, ir_flush_n, en_ir_out_n,
    input  opcode, ir_out_oe, cur_valid, count, empty, full, overflow
  );

  modport slave (
    input  ir_in, en_ir_in_n, ir_next_n, ir_flush_n, en_ir_out_n,
    output opcode, ir_out_oe, cur_valid, count, empty, full, overflow
  );

endinterface

// File: rtl/ir_prefetch_queue_fifo.sv
// Circular word buffer with head/tail pointers, occupancy count and sticky overflow.
module ir_prefetch_queue_fifo
  import ir_prefetch_queue_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth,
  localparam int unsigned CntW = count_w(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             we;
  logic [PtrW-1:0]  waddr;
  fifo_op_e         op;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CntW'(Depth));
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign rdata_o    = mem_q[head_q];
  assign op         = fifo_op_e'({push_i, pop_i});

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    waddr   = tail_q;
    if (flush_i) begin
      // A push alongside a flush lands in slot 0 of the freshly emptied queue.
      head_d  = '0;
      tail_d  = PtrW'(push_i);
      count_d = CntW'(push_i);
      we      = push_i;
      waddr   = '0;
    end else begin
      unique case (op)
        OpPush: begin
          if (full_o) begin
            ovf_d = 1'b1;
          end else begin
            we      = 1'b1;
            tail_d  = tail_q + PtrW'(1);
            count_d = count_q + CntW'(1);
          end
        end
        OpPop: begin
          if (!empty_o) begin
            head_d  = head_q + PtrW'(1);
            count_d = count_q - CntW'(1);
          end
        end
        OpBoth: begin
          // Empty push+pop is a bypass handled outside; the queue is untouched.
          if (!empty_o) begin
            we     = 1'b1;
            head_d = head_q + PtrW'(1);
            tail_d = tail_q + PtrW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= wdata_i;
    end
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a prefetch queue; current word drives the opcode and operand bus.
module ir_prefetch_queue
  import ir_prefetch_queue_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned OpcW  = DefOpcW,
  parameter int unsigned Depth = DefDepth
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ir_prefetch_queue_if.slave bus_io,
  output wire [Width-1:0]   ir_out_o
);

  localparam int unsigned CntW = count_w(Depth);
  localparam int unsigned OpdW = Width - OpcW;

  logic [Width-1:0] cur_q, cur_d;
  logic             valid_q, valid_d;
  logic             push, pop, flush;
  logic [Width-1:0] head_word;
  logic [CntW-1:0]  count;
  logic             empty;
  logic             full;
  logic             overflow;

  assign push  = ~bus_io.en_ir_in_n;
  assign pop   = ~bus_io.ir_next_n;
  assign flush = ~bus_io.ir_flush_n;

  ir_prefetch_queue_fifo #(
    .Width (Width),
    .Depth (Depth)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (bus_io.ir_in),
    .rdata_o    (head_word),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .overflow_o (overflow)
  );

  always_comb begin
    cur_d   = cur_q;
    valid_d = valid_q;
    if (flush) begin
      cur_d   = '0;
      valid_d = 1'b0;
    end else if (pop) begin
      if (!empty) begin
        cur_d   = head_word;
        valid_d = 1'b1;
      end else if (push) begin
        cur_d   = bus_io.ir_in;
        valid_d = 1'b1;
      end else begin
        cur_d   = {OpcW'(NopOpcode), OpdW'(0)};
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      valid_q <= valid_d;
    end
  end

  assign bus_io.opcode    = cur_q[Width-1 -: OpcW];
  assign bus_io.cur_valid = valid_q;
  assign bus_io.count     = count;
  assign bus_io.empty     = empty;
  assign bus_io.full      = full;
  assign bus_io.overflow  = overflow;
  assign bus_io.ir_out_oe = ~bus_io.en_ir_out_n;

  // Opcode bits are zeroed on the bus so only the operand is ever exposed.
  assign ir_out_o = bus_io.ir_out_oe ? {OpcW'(0), cur_q[OpdW-1:0]} : {Width{1'bz}};

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed self-checking bench for ir_prefetch_queue at default and 12/4/8 parameters.
module tb_ir_prefetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  ir_prefetch_queue_if #(.Width(8), .OpcW(4), .Depth(4)) bus_a ();
  ir_prefetch_queue_if #(.Width(12), .OpcW(4), .Depth(8)) bus_b ();
  wire [7:0]  ir_out_a;
  wire [11:0] ir_out_b;

  ir_prefetch_queue #(.Width(8), .OpcW(4), .Depth(4)) u_dut_a (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus_io   (bus_a),
    .ir_out_o (ir_out_a)
  );

  ir_prefetch_queue #(.Width(12), .OpcW(4), .Depth(8)) u_dut_b (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus_io   (bus_b),
    .ir_out_o (ir_out_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc_a(input logic push, input logic pop, input logic flush,
                       input logic [7:0] d);
    bus_a.ir_in      = d;
    bus_a.en_ir_in_n = ~push;
    bus_a.ir_next_n  = ~pop;
    bus_a.ir_flush_n = ~flush;
    @(posedge clk);
    #1;
    bus_a.en_ir_in_n = 1'b1;
    bus_a.ir_next_n  = 1'b1;
    bus_a.ir_flush_n = 1'b1;
  endtask

  task automatic cyc_b(input logic push, input logic pop, input logic [11:0] d);
    bus_b.ir_in      = d;
    bus_b.en_ir_in_n = ~push;
    bus_b.ir_next_n  = ~pop;
    @(posedge clk);
    #1;
    bus_b.en_ir_in_n = 1'b1;
    bus_b.ir_next_n  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] word_a(input int i);
    return 8'(i * 37 + 5);
  endfunction

  function automatic logic [11:0] word_b(input int i);
    return 12'(i * 299 + 7);
  endfunction

  initial begin
    logic [7:0]  wa;
    logic [11:0] wb;
    bus_a.ir_in = '0; bus_a.en_ir_in_n = 1'b1; bus_a.ir_next_n = 1'b1;
    bus_a.ir_flush_n = 1'b1; bus_a.en_ir_out_n = 1'b1;
    bus_b.ir_in = '0; bus_b.en_ir_in_n = 1'b1; bus_b.ir_next_n = 1'b1;
    bus_b.ir_flush_n = 1'b1; bus_b.en_ir_out_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_count", 32'(bus_a.count), 0);
    check("rst_empty", 32'(bus_a.empty), 1);
    check("rst_full", 32'(bus_a.full), 0);
    check("rst_opcode", 32'(bus_a.opcode), 0);
    check("rst_valid", 32'(bus_a.cur_valid), 0);

    // Reset mid-stream with COUNT=3 and a valid current word.
    cyc_a(1, 0, 0, 8'h1A); cyc_a(1, 0, 0, 8'h2B); cyc_a(1, 0, 0, 8'h3C); cyc_a(1, 0, 0, 8'h4D);
    cyc_a(0, 1, 0, 8'h00);
    check("pre_rst_count", 32'(bus_a.count), 3);
    check("pre_rst_valid", 32'(bus_a.cur_valid), 1);
    check("pre_rst_opcode", 32'(bus_a.opcode), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(bus_a.count), 0);
    check("mid_rst_opcode", 32'(bus_a.opcode), 0);
    check("mid_rst_valid", 32'(bus_a.cur_valid), 0);
    check("mid_rst_ovf", 32'(bus_a.overflow), 0);
    check("mid_rst_oe", 32'(bus_a.ir_out_oe), 0);
    rst = 1'b0;

    // In-order pops with operand on the bus.
    cyc_a(1, 0, 0, 8'h1A); cyc_a(1, 0, 0, 8'h2B); cyc_a(1, 0, 0, 8'h3C);
    bus_a.en_ir_out_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc_a(0, 1, 0, 8'h00);
      check("seq_opcode", 32'(bus_a.opcode), 32'(k + 1));
      check("seq_ir_out", 32'(ir_out_a), 32'(8'h0A + k));
      check("seq_oe", 32'(bus_a.ir_out_oe), 1);
    end
    check("seq_empty", 32'(bus_a.empty), 1);
    bus_a.en_ir_out_n = 1'b1;
    #1 check("seq_oe_off", 32'(bus_a.ir_out_oe), 0);

    // Overflow on fifth push; only the first four come back.
    do_reset();
    for (int k = 0; k < 5; k++) cyc_a(1, 0, 0, 8'((k + 1) * 8'h11));
    check("ovf_full", 32'(bus_a.full), 1);
    check("ovf_count", 32'(bus_a.count), 4);
    check("ovf_flag", 32'(bus_a.overflow), 1);
    for (int k = 0; k < 4; k++) begin
      cyc_a(0, 1, 0, 8'h00);
      check("ovf_pop_opcode", 32'(bus_a.opcode), 32'(k + 1));
    end
    cyc_a(0, 1, 0, 8'h00);
    check("nop_opcode", 32'(bus_a.opcode), 0);
    check("nop_valid", 32'(bus_a.cur_valid), 0);
    check("ovf_sticky", 32'(bus_a.overflow), 1);
    check("nop_empty", 32'(bus_a.empty), 1);

    // Bypass on empty, then push+pop while full.
    do_reset();
    cyc_a(1, 1, 0, 8'h5E);
    check("byp_opcode", 32'(bus_a.opcode), 5);
    check("byp_valid", 32'(bus_a.cur_valid), 1);
    check("byp_count", 32'(bus_a.count), 0);
    for (int k = 1; k <= 4; k++) cyc_a(1, 0, 0, 8'(8'h60 + k));
    check("fp_full_pre", 32'(bus_a.full), 1);
    cyc_a(1, 1, 0, 8'h65);
    check("fp_count", 32'(bus_a.count), 4);
    check("fp_ovf", 32'(bus_a.overflow), 0);
    check("fp_opcode", 32'(bus_a.opcode), 6);
    bus_a.en_ir_out_n = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      cyc_a(0, 1, 0, 8'h00);
      check("fp_drain", 32'(ir_out_a), 32'(k));
    end
    bus_a.en_ir_out_n = 1'b1;

    // Flush with simultaneous push keeps only the jump-target word.
    do_reset();
    cyc_a(1, 0, 0, 8'h81); cyc_a(1, 0, 0, 8'h92); cyc_a(1, 0, 0, 8'hA3);
    cyc_a(0, 1, 0, 8'h00);
    cyc_a(1, 0, 0, 8'hB4);
    check("fl_pre_count", 32'(bus_a.count), 3);
    cyc_a(1, 1, 1, 8'h7F);
    check("fl_count", 32'(bus_a.count), 1);
    check("fl_valid", 32'(bus_a.cur_valid), 0);
    check("fl_opcode", 32'(bus_a.opcode), 0);
    cyc_a(0, 1, 0, 8'h00);
    check("fl_pop_opcode", 32'(bus_a.opcode), 7);
    check("fl_pop_valid", 32'(bus_a.cur_valid), 1);
    check("fl_pop_count", 32'(bus_a.count), 0);

    // Pointer wrap over 3*DEPTH streaming push+pop, default parameters.
    do_reset();
    bus_a.en_ir_out_n = 1'b0;
    cyc_a(1, 0, 0, word_a(0));
    for (int i = 1; i <= 12; i++) begin
      cyc_a(1, 1, 0, word_a(i));
      wa = word_a(i - 1);
      check("wrap_a_opcode", 32'(bus_a.opcode), 32'(wa[7:4]));
      check("wrap_a_ir_out", 32'(ir_out_a), 32'({4'h0, wa[3:0]}));
    end
    check("wrap_a_count", 32'(bus_a.count), 1);
    bus_a.en_ir_out_n = 1'b1;

    // Same with 12/4/8: fill to FULL, then stream 3*DEPTH through.
    do_reset();
    bus_b.en_ir_out_n = 1'b0;
    for (int i = 0; i < 8; i++) cyc_b(1, 0, word_b(i));
    check("wrap_b_full", 32'(bus_b.full), 1);
    check("wrap_b_count8", 32'(bus_b.count), 8);
    for (int i = 8; i < 32; i++) begin
      cyc_b(1, 1, word_b(i));
      wb = word_b(i - 8);
      check("wrap_b_opcode", 32'(bus_b.opcode), 32'(wb[11:8]));
      check("wrap_b_ir_out", 32'(ir_out_b), 32'({4'h0, wb[7:0]}));
    end
    check("wrap_b_ovf", 32'(bus_b.overflow), 0);
    check("wrap_b_count", 32'(bus_b.count), 8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
